wave_meas: RTL and testbench
============================

Name: wave_meas

Overview:
Measures a sampled waveform stream, inverting the generator's parameterisation. It recovers peak-to-peak amplitude, bias (mid-level) and period from 12-bit samples, as produced by the triangle/signal generators or the ADC capture path. Results are published once per fixed window of valid samples to the display/readout logic.

Parameters:
DW, 12, sample and result width
WIN_LOG2, 10, window length = 2**WIN_LOG2 valid samples
PER_W, 16, period counter/result width
HYST, 8, crossing hysteresis in LSBs either side of the threshold

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
clear  input  1  synchronous restart of current window; results retained
sample_valid  input  1  sample_in is valid this cycle
sample_in  input  DW  unsigned sample
meas_valid  output  1  one-cycle pulse: new results valid
p2p_out  output  DW  max - min over last window
bias_out  output  DW  floor((max + min) / 2) over last window
period_out  output  PER_W  most recent completed period, in valid samples
period_ok  output  1  period_out measured within last window and not saturated

Behaviour:
- Reset (rst_n=0 at clk edge): all outputs 0; window count 0; min=all-ones, max=0; threshold=2**(DW-1) (2048); crossing tracker disarmed, no prior crossing, counter 0.
- Only cycles with sample_valid=1 advance anything. Gaps are ignored.
- FSM: ACQ -> PUBLISH -> ACQ.
  - ACQ: each valid sample updates min/max and increments the window count.
  - On the 2**WIN_LOG2-th valid sample, that sample is included and the FSM goes to PUBLISH.
  - PUBLISH (one cycle): register p2p_out, bias_out, period_out and period_ok; pulse meas_valid; set threshold := new bias; reinit min/max and window count; return to ACQ.
  - Latency: meas_valid is high exactly the cycle after the last window sample's edge.
  - A sample_valid during PUBLISH is accepted into the new window; no sample is dropped.
- Arithmetic: bias sum is DW+1 bits, then shifted right 1. p2p is an unsigned DW-bit difference, never negative.
- Crossing tracker runs continuously across windows:
  - lo = max(thr-HYST, 0); hi = min(thr+HYST, 2**DW-1).
  - Arm when sample < lo. A rising crossing occurs when armed and sample >= hi; disarm on the crossing.
  - Counter increments per valid sample and saturates at 2**PER_W-1.
  - At a crossing, with a prior crossing: latch period = counter value (sample index difference) and set the saturated flag if the counter was saturated. In all cases reset the counter to 0 (counting restarts at the crossing sample) and mark a prior crossing seen.
- period_ok at PUBLISH = a period was latched since the previous PUBLISH and that period was not saturated. If period_ok=0, period_out holds its old value.
- The threshold changes only at PUBLISH; the armed state is kept across the change.
- clear=1: window count and min/max reinit; FSM to ACQ; tracker reset to disarmed with no prior crossing; outputs and threshold unchanged.
  - clear has priority over sample_valid in the same cycle; the sample is discarded.
  - clear coinciding with the last window sample: no publish.
- Reset mid-window: identical to the reset state, including threshold 2048.

Decomposition:
- Package scope_pkg: DW default, MIDSCALE constant (2**(DW-1)), state enum {ACQ, PUBLISH}.
- Sub-module wave_cross_det: hysteresis comparator, period counter, saturation and period-latched flags. Inputs: sample, valid, threshold, clear. Outputs: period, period_new, saturated.
- Min/max and the FSM stay in wave_meas.

Test Plan:
1. Reset: hold rst_n=0 over several edges with sample_valid=1 -> all outputs 0, no meas_valid; first publish occurs exactly 1024 valid samples after release.
2. Triangle from generator (p2p=100, bias=1000, one sample per clk, range 950..1050):
   - first meas_valid -> p2p_out=100, bias_out=1000, period_ok=0 (threshold 2048 unreachable).
   - second meas_valid -> period_out=200, period_ok=1.
3. Constant 500 -> p2p_out=0, bias_out=500, period_ok=0 on every publish.
4. Alternating 0/4095 with sample_valid toggling every other cycle -> p2p_out=4095, bias_out=2047; meas_valid after 1024 valid samples (~2048 clocks); period_out=2, period_ok=1 from the second window.
5. Slow square wave 0/4000, 70000-sample period -> counter saturates at 65535; period_ok=0 and period_out unchanged.
6. clear asserted at valid sample 600, and separately on the 1024th sample -> no meas_valid for the aborted window; next publish 1024 valid samples after clear; previous results held throughout.

Source files
------------

// File: rtl/scope_pkg.sv
// Shared types and constants for the waveform measurement block.
package scope_pkg;

  localparam int DW_DEFAULT = 12;
  localparam logic [DW_DEFAULT-1:0] MIDSCALE = {1'b1, {(DW_DEFAULT-1){1'b0}}};

  typedef enum logic {
    ACQ     = 1'b0,
    PUBLISH = 1'b1
  } state_t;

endpackage

// File: rtl/wave_meas_if.sv
// Sample stream in, measurement results out.
interface wave_meas_if #(
  parameter int DW    = 12,
  parameter int PER_W = 16
);
  logic             clear;
  logic             sample_valid;
  logic [DW-1:0]    sample_in;
  logic             meas_valid;
  logic [DW-1:0]    p2p_out;
  logic [DW-1:0]    bias_out;
  logic [PER_W-1:0] period_out;
  logic             period_ok;

  modport master (
    output clear, sample_valid, sample_in,
    input  meas_valid, p2p_out, bias_out, period_out, period_ok
  );

  modport slave (
    input  clear, sample_valid, sample_in,
    output meas_valid, p2p_out, bias_out, period_out, period_ok
  );
endinterface

// File: rtl/wave_cross_det.sv
// Rising-crossing detector with hysteresis; measures period in valid samples.
module wave_cross_det #(
  parameter int DW    = 12,
  parameter int PER_W = 16,
  parameter int HYST  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_clear,
  input  logic             i_valid,
  input  logic             i_ack,
  input  logic [DW-1:0]    i_sample,
  input  logic [DW-1:0]    i_thr,
  output logic [PER_W-1:0] o_period,
  output logic             o_period_new,
  output logic             o_saturated
);

  localparam logic [DW-1:0] HYST_V = DW'(HYST);
  localparam logic [DW-1:0] TOP_V  = '1;

  logic             r_armed;
  logic             r_prior;
  logic [PER_W-1:0] r_cnt;
  logic [PER_W-1:0] r_period;
  logic             r_new;
  logic             r_sat;

  logic [DW-1:0]    w_lo;
  logic [DW-1:0]    w_hi;
  logic             w_below;
  logic             w_cross;
  logic             w_cnt_max;
  logic [PER_W-1:0] w_cnt_inc;

  // Band edges clamp to the code range instead of wrapping.
  assign w_lo      = (i_thr < HYST_V) ? '0 : i_thr - HYST_V;
  assign w_hi      = (i_thr > TOP_V - HYST_V) ? TOP_V : i_thr + HYST_V;
  assign w_below   = i_sample < w_lo;
  assign w_cross   = r_armed && (i_sample >= w_hi);
  assign w_cnt_max = &r_cnt;
  assign w_cnt_inc = w_cnt_max ? r_cnt : r_cnt + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_armed  <= 1'b0;
      r_prior  <= 1'b0;
      r_cnt    <= '0;
      r_period <= '0;
      r_new    <= 1'b0;
      r_sat    <= 1'b0;
    end else if (i_clear) begin
      r_armed <= 1'b0;
      r_prior <= 1'b0;
      r_cnt   <= '0;
      r_new   <= 1'b0;
    end else begin
      // A crossing on the publishing sample belongs to the next window.
      if (i_ack) r_new <= 1'b0;
      if (i_valid) begin
        if (w_cross) begin
          r_armed <= 1'b0;
          r_prior <= 1'b1;
          r_cnt   <= '0;
          if (r_prior) begin
            r_period <= w_cnt_inc;
            r_sat    <= w_cnt_max;
            r_new    <= 1'b1;
          end
        end else begin
          if (w_below) r_armed <= 1'b1;
          r_cnt <= w_cnt_inc;
        end
      end
    end
  end

  assign o_period     = r_period;
  assign o_period_new = r_new;
  assign o_saturated  = r_sat;

endmodule

// File: rtl/wave_meas.sv
// Windowed amplitude / bias / period measurement of a sample stream.
module wave_meas
  import scope_pkg::*;
#(
  parameter int DW       = DW_DEFAULT,
  parameter int WIN_LOG2 = 10,
  parameter int PER_W    = 16,
  parameter int HYST     = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  wave_meas_if.slave bus
);

  localparam logic [DW-1:0] THR_RST = {1'b1, {(DW-1){1'b0}}};

  state_t              r_state;
  logic [WIN_LOG2-1:0] r_cnt;
  logic [DW-1:0]       r_min;
  logic [DW-1:0]       r_max;
  logic [DW-1:0]       r_thr;
  logic [DW-1:0]       r_p2p;
  logic [DW-1:0]       r_bias;
  logic [PER_W-1:0]    r_per;
  logic                r_ok;

  logic                w_accept;
  logic                w_last;
  logic [DW-1:0]       w_min;
  logic [DW-1:0]       w_max;
  logic [DW:0]         w_sum;
  logic [DW-1:0]       w_bias;
  logic [DW-1:0]       w_p2p;
  logic [PER_W-1:0]    w_period;
  logic                w_period_new;
  logic                w_saturated;
  logic                w_per_ok;

  assign w_accept = bus.sample_valid & ~bus.clear;
  assign w_last   = w_accept & (&r_cnt);
  assign w_min    = (bus.sample_in < r_min) ? bus.sample_in : r_min;
  assign w_max    = (bus.sample_in > r_max) ? bus.sample_in : r_max;
  assign w_sum    = {1'b0, w_max} + {1'b0, w_min};
  assign w_bias   = DW'(w_sum >> 1);
  assign w_p2p    = w_max - w_min;
  assign w_per_ok = w_period_new & ~w_saturated;

  wave_cross_det #(
    .DW    (DW),
    .PER_W (PER_W),
    .HYST  (HYST)
  ) u_cross (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_clear      (bus.clear),
    .i_valid      (bus.sample_valid),
    .i_ack        (w_last),
    .i_sample     (bus.sample_in),
    .i_thr        (r_thr),
    .o_period     (w_period),
    .o_period_new (w_period_new),
    .o_saturated  (w_saturated)
  );

  // Results are registered on the last sample's edge so meas_valid (PUBLISH)
  // is high in the very next cycle; PUBLISH already accepts samples.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ACQ;
      r_cnt   <= '0;
      r_min   <= '1;
      r_max   <= '0;
      r_thr   <= THR_RST;
      r_p2p   <= '0;
      r_bias  <= '0;
      r_per   <= '0;
      r_ok    <= 1'b0;
    end else if (bus.clear) begin
      r_state <= ACQ;
      r_cnt   <= '0;
      r_min   <= '1;
      r_max   <= '0;
    end else if (w_last) begin
      r_state <= PUBLISH;
      r_p2p   <= w_p2p;
      r_bias  <= w_bias;
      r_thr   <= w_bias;
      r_ok    <= w_per_ok;
      if (w_per_ok) r_per <= w_period;
      r_cnt   <= '0;
      r_min   <= '1;
      r_max   <= '0;
    end else begin
      r_state <= ACQ;
      if (w_accept) begin
        r_min <= w_min;
        r_max <= w_max;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign bus.meas_valid = (r_state == PUBLISH);
  assign bus.p2p_out    = r_p2p;
  assign bus.bias_out   = r_bias;
  assign bus.period_out = r_per;
  assign bus.period_ok  = r_ok;

endmodule

// File: tb/tb_wave_meas.sv
// Randomised and directed stimulus against a sample-index reference model.
module tb_wave_meas;
  import scope_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;

  wave_meas_if #(.DW(12), .PER_W(16)) bus();

  wave_meas #(.DW(12), .WIN_LOG2(10), .PER_W(16), .HYST(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: window as a queue, crossings as absolute sample indices.
  int     win[$];
  int     m_thr;
  bit     m_armed, m_prior, m_new, m_sat;
  longint m_idx, m_last;
  int     m_lat;
  bit     m_mv, m_ok;
  int     m_p2p, m_bias, m_per;

  task automatic model_edge(input bit r, input bit c, input bit v, input int s);
    int lo, hi, mn, mx, thr_old;
    longint d;
    if (!r) begin
      win.delete();
      m_thr = int'(MIDSCALE); m_armed = 0; m_prior = 0; m_new = 0; m_sat = 0;
      m_lat = 0; m_mv = 0; m_ok = 0; m_p2p = 0; m_bias = 0; m_per = 0;
      m_idx = 0; m_last = 0;
      return;
    end
    m_mv = 0;
    thr_old = m_thr;
    if (c) begin
      win.delete(); m_armed = 0; m_prior = 0; m_new = 0;
      return;
    end
    if (!v) return;
    m_idx++;
    win.push_back(s);
    if (win.size() == 1024) begin
      mn = 4095; mx = 0;
      foreach (win[i]) begin
        if (win[i] < mn) mn = win[i];
        if (win[i] > mx) mx = win[i];
      end
      m_mv = 1; m_p2p = mx - mn; m_bias = (mx + mn) / 2;
      m_ok = m_new && !m_sat;
      if (m_ok) m_per = m_lat;
      m_thr = m_bias; m_new = 0;
      win.delete();
    end
    lo = (thr_old - 8 < 0) ? 0 : thr_old - 8;
    hi = (thr_old + 8 > 4095) ? 4095 : thr_old + 8;
    if (s < lo) m_armed = 1;
    else if (m_armed && s >= hi) begin
      m_armed = 0;
      if (m_prior) begin
        d = m_idx - m_last;
        m_lat = (d > 65535) ? 65535 : int'(d);
        m_sat = (d > 65535);
        m_new = 1;
      end
      m_last = m_idx; m_prior = 1;
    end
  endtask

  function automatic logic [41:0] dut_vec();
    return {bus.meas_valid, bus.p2p_out, bus.bias_out, bus.period_out, bus.period_ok};
  endfunction

  function automatic logic [41:0] mdl_vec();
    return {m_mv, 12'(m_p2p), 12'(m_bias), 16'(m_per), m_ok};
  endfunction

  function automatic int tri_wave(input int k);
    int p = k % 200;
    return 950 + ((p <= 100) ? p : 200 - p);
  endfunction

  task automatic step(input bit r, input bit c, input bit v, input int s);
    rst_n = r; bus.clear = c; bus.sample_valid = v; bus.sample_in = 12'(s);
    @(posedge clk);
    model_edge(r, c, v, s);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, int'($urandom_range(0, 4095)));
      tests++;
      if (dut_vec() !== 42'd0) begin
        fails++; $display("FAIL reset_state: got %h want 0", dut_vec());
      end
    end
    for (int i = 1; i <= 1024; i++) begin
      step(1, 0, 1, int'($urandom_range(0, 4095)));
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++; if (fails < 20) $display("FAIL reset_model i=%0d: got %h want %h", i, dut_vec(), mdl_vec());
      end
      if (i >= 1023) begin
        tests++;
        if (bus.meas_valid !== (i == 1024)) begin
          fails++; $display("FAIL first_pub i=%0d: got mv=%b want %b", i, bus.meas_valid, (i == 1024));
        end
      end
    end
  endtask

  task automatic test_triangle();
    int npub = 0;
    step(0, 0, 0, 0);
    for (int k = 0; k < 2048; k++) begin
      step(1, 0, 1, tri_wave(k));
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++; if (fails < 20) $display("FAIL tri_model k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
      end
      if (bus.meas_valid === 1'b1) begin
        npub++;
        tests++;
        if (npub == 1 && {bus.p2p_out, bus.bias_out, bus.period_ok} !== {12'd100, 12'd1000, 1'b0}) begin
          fails++; $display("FAIL tri_first: got p2p=%0d bias=%0d ok=%b want 100 1000 0", bus.p2p_out, bus.bias_out, bus.period_ok);
        end
        if (npub == 2 && {bus.period_out, bus.period_ok} !== {16'd200, 1'b1}) begin
          fails++; $display("FAIL tri_period: got per=%0d ok=%b want 200 1", bus.period_out, bus.period_ok);
        end
      end
    end
    tests++;
    if (npub != 2) begin fails++; $display("FAIL tri_count: got %0d want 2", npub); end
  endtask

  task automatic test_constant();
    int npub = 0;
    step(1, 1, 0, 0);
    for (int k = 0; k < 2048; k++) begin
      step(1, 0, 1, 500);
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++; if (fails < 20) $display("FAIL const_model k=%0d: got %h want %h", k, dut_vec(), mdl_vec());
      end
      if (bus.meas_valid === 1'b1) begin
        npub++;
        tests++;
        if ({bus.p2p_out, bus.bias_out, bus.period_ok} !== {12'd0, 12'd500, 1'b0}) begin
          fails++; $display("FAIL const_pub: got p2p=%0d bias=%0d ok=%b want 0 500 0", bus.p2p_out, bus.bias_out, bus.period_ok);
        end
      end
    end
    tests++;
    if (npub != 2) begin fails++; $display("FAIL const_count: got %0d want 2", npub); end
  endtask

  task automatic test_alternating();
    int npub = 0;
    int first_at = -1;
    step(1, 1, 0, 0);
    for (int i = 0; i < 4096; i++) begin
      step(1, 0, (i % 2 == 0), (((i / 2) % 2) != 0) ? 4095 : 0);
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++; if (fails < 20) $display("FAIL alt_model i=%0d: got %h want %h", i, dut_vec(), mdl_vec());
      end
      if (bus.meas_valid === 1'b1) begin
        npub++;
        if (first_at < 0) first_at = i;
        tests++;
        if ({bus.p2p_out, bus.bias_out} !== {12'd4095, 12'd2047}) begin
          fails++; $display("FAIL alt_levels: got p2p=%0d bias=%0d want 4095 2047", bus.p2p_out, bus.bias_out);
        end
        if (npub == 2) begin
          tests++;
          if ({bus.period_out, bus.period_ok} !== {16'd2, 1'b1}) begin
            fails++; $display("FAIL alt_period: got per=%0d ok=%b want 2 1", bus.period_out, bus.period_ok);
          end
        end
      end
    end
    tests++;
    if (first_at != 2046 || npub != 2) begin
      fails++; $display("FAIL alt_timing: got first=%0d n=%0d want 2046 2", first_at, npub);
    end
  endtask

  task automatic test_clear();
    step(1, 1, 0, 0);
    for (int i = 0; i < 599; i++) step(1, 0, 1, int'($urandom_range(1000, 3000)));
    step(1, 1, 1, int'($urandom_range(1000, 3000)));
    tests++;
    if ({bus.meas_valid, bus.p2p_out, bus.bias_out, bus.period_out, bus.period_ok} !==
        {1'b0, 12'd4095, 12'd2047, 16'd2, 1'b1}) begin
      fails++; $display("FAIL clear_hold: got %h want held results", dut_vec());
    end
    for (int i = 1; i <= 1024; i++) begin
      step(1, 0, 1, int'($urandom_range(1000, 3000)));
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++; if (fails < 20) $display("FAIL clear_model i=%0d: got %h want %h", i, dut_vec(), mdl_vec());
      end
      tests++;
      if (bus.meas_valid !== (i == 1024) || (i < 1024 && bus.p2p_out !== 12'd4095)) begin
        fails++; $display("FAIL clear_restart i=%0d: got mv=%b p2p=%0d", i, bus.meas_valid, bus.p2p_out);
      end
    end
    for (int i = 1; i <= 1023; i++) step(1, 0, 1, int'($urandom_range(1000, 3000)));
    step(1, 1, 1, int'($urandom_range(1000, 3000)));
    step(1, 0, 0, 0);
    tests++;
    if (bus.meas_valid !== 1'b0 || dut_vec() !== mdl_vec()) begin
      fails++; $display("FAIL clear_last: got %h want %h", dut_vec(), mdl_vec());
    end
    for (int i = 1; i <= 1024; i++) begin
      step(1, 0, 1, int'($urandom_range(0, 4095)));
      tests++;
      if (bus.meas_valid !== (i == 1024) || dut_vec() !== mdl_vec()) begin
        fails++; if (fails < 20) $display("FAIL clear_last_restart i=%0d: got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_random();
    int pos = 0, half = 10, level = 0;
    int lo_l = 200, hi_l = 3500;
    for (int i = 0; i < 3000; i++) begin
      bit c = ($urandom_range(0, 499) == 0);
      bit v = ($urandom_range(0, 9) < 7);
      if (v) begin
        pos++;
        if (pos >= half) begin
          pos = 0; level = 1 - level;
          half = int'($urandom_range(2, 40));
          lo_l = int'($urandom_range(0, 1500));
          hi_l = int'($urandom_range(2500, 4075));
        end
      end
      step(1, c, v, (level != 0 ? hi_l : lo_l) + int'($urandom_range(0, 20)));
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++; if (fails < 20) $display("FAIL rand_model i=%0d: got %h want %h", i, dut_vec(), mdl_vec());
      end
    end
  endtask

  task automatic test_saturation();
    int npub_c = 0;
    step(1, 0, 1, 100);
    step(0, 0, 1, 100);
    tests++;
    if (dut_vec() !== 42'd0) begin fails++; $display("FAIL midreset: got %h want 0", dut_vec()); end
    for (int j = 0; j < 1024; j++) begin
      step(1, 0, 1, (((j / 4) % 2) != 0) ? 4000 : 0);
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++; if (fails < 20) $display("FAIL sat_a_model j=%0d: got %h want %h", j, dut_vec(), mdl_vec());
      end
    end
    tests++;
    if ({bus.meas_valid, bus.p2p_out, bus.bias_out, bus.period_out, bus.period_ok} !==
        {1'b1, 12'd4000, 12'd2000, 16'd8, 1'b1}) begin
      fails++; $display("FAIL sat_fast: got %h want p2p 4000 bias 2000 per 8 ok 1", dut_vec());
    end
    for (int j = 0; j < 65600; j++) begin
      step(1, 0, 1, 0);
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++; if (fails < 20) $display("FAIL sat_b_model j=%0d: got %h want %h", j, dut_vec(), mdl_vec());
      end
      if (bus.meas_valid === 1'b1) begin
        tests++;
        if ({bus.period_out, bus.period_ok} !== {16'd8, 1'b0}) begin
          fails++; if (fails < 20) $display("FAIL sat_low: got per=%0d ok=%b want 8 0", bus.period_out, bus.period_ok);
        end
      end
    end
    for (int j = 0; j < 960; j++) begin
      step(1, 0, 1, 4000);
      tests++;
      if (dut_vec() !== mdl_vec()) begin
        fails++; if (fails < 20) $display("FAIL sat_c_model j=%0d: got %h want %h", j, dut_vec(), mdl_vec());
      end
      if (bus.meas_valid === 1'b1) npub_c++;
    end
    tests++;
    if (npub_c != 1 || {bus.meas_valid, bus.p2p_out, bus.bias_out, bus.period_out, bus.period_ok} !==
        {1'b1, 12'd4000, 12'd2000, 16'd8, 1'b0}) begin
      fails++; $display("FAIL sat_long: got %h n=%0d want per 8 ok 0 n=1", dut_vec(), npub_c);
    end
  endtask

  initial begin
    bus.clear = 1'b0; bus.sample_valid = 1'b0; bus.sample_in = '0;
    test_reset();
    test_triangle();
    test_constant();
    test_alternating();
    test_clear();
    test_random();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
